// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC sequencer feeding a synchronous instruction ROM, with a
//            DEPTH-entry prefetch FIFO and branch/jump redirect handling.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                ADDR_W     = 8,
  parameter int                INST_W     = 16,
  parameter int                OFF_W      = 8,
  parameter int                DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter bit                REL_BRANCH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [OFF_W-1:0]  branch_offset
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
  logic [INST_W-1:0] mem_inst_q [DEPTH];

  logic              w_pop;
  logic              w_push;
  logic [CW:0]       w_occ;
  logic [CW:0]       w_lim;
  logic [ADDR_W-1:0] w_off_sx;
  logic [ADDR_W-1:0] w_off_zx;
  logic [ADDR_W-1:0] w_target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  if (OFF_W == ADDR_W) begin : g_off_full
    assign w_off_sx = branch_offset;
    assign w_off_zx = branch_offset;
  end else begin : g_off_ext
    assign w_off_sx = {{(ADDR_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};
    assign w_off_zx = {{(ADDR_W-OFF_W){1'b0}}, branch_offset};
  end

  assign w_target = REL_BRANCH ? (branch_pc + w_off_sx) : w_off_zx;

  assign inst_valid = (count_q != '0);
  assign inst       = mem_inst_q[rd_ptr_q];
  assign inst_pc    = mem_pc_q[rd_ptr_q];
  assign imem_addr  = fetch_pc_q;

  assign w_pop  = inst_valid & inst_ready;
  // A redirect squashes the returning word: it belongs to the old path.
  assign w_push = inflight_q & ~redirect;

  // Reserve a slot for every outstanding read; a pop this cycle frees one.
  assign w_occ    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign w_lim    = (CW+1)'(DEPTH) + {{CW{1'b0}}, w_pop};
  assign imem_req = reset & ~redirect & (w_occ < w_lim);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (imem_req) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
      inflight_pc_d = fetch_pc_q;
    end
    if (redirect) begin
      fetch_pc_d = w_target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (w_push && !w_pop)      count_d = count_q + CW'(1);
      else if (!w_push && w_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Storage is cleared too so the head reads as zero while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_inst_q[i] <= '0;
      end
    end else if (w_push) begin
      mem_pc_q[wr_ptr_q]   <= inflight_pc_q;
      mem_inst_q[wr_ptr_q] <= imem_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Bench for fetch_unit: directed scenarios on two configurations plus a
// randomized ready/redirect run checked against an in-order stream model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  int          tests;
  int          fails;

  logic        req1, valid1, ready1, redir1;
  logic [7:0]  addr1, pc1, bpc1, boff1;
  logic [15:0] data1, inst1;
  logic        req2, valid2, ready2, redir2;
  logic [7:0]  addr2, pc2, bpc2, boff2;
  logic [15:0] data2, inst2;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(req1), .imem_addr(addr1), .imem_data(data1),
    .inst_valid(valid1), .inst_ready(ready1), .inst(inst1), .inst_pc(pc1),
    .redirect(redir1), .branch_pc(bpc1), .branch_offset(boff1)
  );

  fetch_unit #(.RESET_PC(8'hFE), .REL_BRANCH(1'b0)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req(req2), .imem_addr(addr2), .imem_data(data2),
    .inst_valid(valid2), .inst_ready(ready2), .inst(inst2), .inst_pc(pc2),
    .redirect(redir2), .branch_pc(bpc2), .branch_offset(boff2)
  );

  function automatic logic [15:0] rom(input logic [7:0] a);
    return {a ^ 8'hA5, a};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (req1) data1 <= rom(addr1);
    if (req2) data2 <= rom(addr2);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b0;
    redir1 = 1'b0;
    redir2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_head1(input logic [7:0] pc);
    bit found = 0;
    for (int i = 0; i < 30; i++) begin
      if (valid1 === 1'b1 && pc1 === pc) begin
        found = 1;
        break;
      end
      next_cycle();
    end
    if (!found) begin
      tests++; fails++;
      $display("FAIL wait_head: head pc %h never seen, last got %h", pc, pc1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (valid1 !== 1'b0 || req1 !== 1'b0) begin
      fails++; $display("FAIL reset_ctl1: got valid=%b req=%b, want 0 0", valid1, req1);
    end
    tests++;
    if (addr1 !== 8'h00) begin fails++; $display("FAIL reset_addr1: got %h, want 00", addr1); end
    tests++;
    if (inst1 !== 16'h0 || pc1 !== 8'h0) begin
      fails++; $display("FAIL reset_head1: got inst=%h pc=%h, want 0 0", inst1, pc1);
    end
    tests++;
    if (valid2 !== 1'b0 || req2 !== 1'b0) begin
      fails++; $display("FAIL reset_ctl2: got valid=%b req=%b, want 0 0", valid2, req2);
    end
    tests++;
    if (addr2 !== 8'hFE) begin fails++; $display("FAIL reset_addr2: got %h, want fe", addr2); end
  endtask

  task automatic test_stream();
    ready1 = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++;
      if (req1 !== 1'b1 || addr1 !== 8'(k)) begin
        fails++;
        $display("FAIL stream_req c%0d: got req=%b addr=%h, want 1 %h", k, req1, addr1, 8'(k));
      end
      tests++;
      if (k < 2) begin
        if (valid1 !== 1'b0) begin
          fails++; $display("FAIL stream_early c%0d: got valid=%b, want 0", k, valid1);
        end
      end else if (valid1 !== 1'b1 || pc1 !== 8'(k-2) || inst1 !== rom(8'(k-2))) begin
        fails++;
        $display("FAIL stream_head c%0d: got v=%b pc=%h inst=%h, want 1 %h %h",
                 k, valid1, pc1, inst1, 8'(k-2), rom(8'(k-2)));
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    ready1 = 1'b1;
    do_reset();
    wait_head1(8'h03);
    ready1 = 1'b0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      tests++;
      if (valid1 !== 1'b1 || pc1 !== 8'h03 || inst1 !== rom(8'h03) || req1 !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold s%0d: got v=%b pc=%h inst=%h req=%b, want 1 03 %h 0",
                 s, valid1, pc1, inst1, req1, rom(8'h03));
      end
      next_cycle();
    end
    ready1 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      tests++;
      if (valid1 !== 1'b1 || pc1 !== 8'(3+j) || inst1 !== rom(8'(3+j))) begin
        fails++;
        $display("FAIL stall_release j%0d: got v=%b pc=%h, want 1 %h", j, valid1, pc1, 8'(3+j));
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    ready1 = 1'b1;
    do_reset();
    wait_head1(8'h05);
    redir1 = 1'b1; bpc1 = 8'h05; boff1 = 8'hFD;
    @(negedge clk);
    tests++;
    if (req1 !== 1'b0 || valid1 !== 1'b1 || pc1 !== 8'h05) begin
      fails++;
      $display("FAIL redir_cycle: got req=%b v=%b pc=%h, want 0 1 05", req1, valid1, pc1);
    end
    next_cycle();
    redir1 = 1'b0;
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      tests++;
      if (j == 1 && (req1 !== 1'b1 || addr1 !== 8'h02 || valid1 !== 1'b0)) begin
        fails++;
        $display("FAIL redir_refetch: got req=%b addr=%h v=%b, want 1 02 0", req1, addr1, valid1);
      end else if (j == 2 && valid1 !== 1'b0) begin
        fails++; $display("FAIL redir_bubble: got v=%b, want 0", valid1);
      end else if (j >= 3 && (valid1 !== 1'b1 || pc1 !== 8'(j-1) || inst1 !== rom(8'(j-1)))) begin
        fails++;
        $display("FAIL redir_target r+%0d: got v=%b pc=%h, want 1 %h", j, valid1, pc1, 8'(j-1));
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap_and_abs();
    logic [7:0] e;
    ready2 = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      e = 8'hFE + 8'(k);
      tests++;
      if (req2 !== 1'b1 || addr2 !== e) begin
        fails++; $display("FAIL wrap_addr c%0d: got req=%b addr=%h, want 1 %h", k, req2, addr2, e);
      end
      if (k >= 2) begin
        e = 8'hFE + 8'(k-2);
        tests++;
        if (valid2 !== 1'b1 || pc2 !== e || inst2 !== rom(e)) begin
          fails++; $display("FAIL wrap_head c%0d: got v=%b pc=%h, want 1 %h", k, valid2, pc2, e);
        end
      end
      next_cycle();
    end
    redir2 = 1'b1; bpc2 = 8'($urandom); boff2 = 8'h40;
    @(negedge clk);
    tests++;
    if (req2 !== 1'b0 || valid2 !== 1'b1 || pc2 !== 8'h02) begin
      fails++;
      $display("FAIL abs_cycle: got req=%b v=%b pc=%h, want 0 1 02", req2, valid2, pc2);
    end
    next_cycle();
    redir2 = 1'b0;
    for (int j = 1; j < 5; j++) begin
      @(negedge clk);
      tests++;
      if (j == 1 && (req2 !== 1'b1 || addr2 !== 8'h40 || valid2 !== 1'b0)) begin
        fails++; $display("FAIL abs_refetch: got req=%b addr=%h v=%b, want 1 40 0", req2, addr2, valid2);
      end else if (j == 2 && valid2 !== 1'b0) begin
        fails++; $display("FAIL abs_bubble: got v=%b, want 0", valid2);
      end else if (j >= 3 && (valid2 !== 1'b1 || pc2 !== 8'(8'h3D + j) || inst2 !== rom(8'(8'h3D + j)))) begin
        fails++; $display("FAIL abs_target r+%0d: got v=%b pc=%h, want 1 %h", j, valid2, pc2, 8'(8'h3D + j));
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    ready1 = 1'b1; ready2 = 1'b1;
    do_reset();
    ready1 = 1'b0; ready2 = 1'b0;
    repeat (6) next_cycle();
    tests++;
    if (valid1 !== 1'b1 || req1 !== 1'b0) begin
      fails++; $display("FAIL areset_pre: got v=%b req=%b, want 1 0", valid1, req1);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (valid1 !== 1'b0 || req1 !== 1'b0 || pc1 !== 8'h00 || inst1 !== 16'h0 || addr1 !== 8'h00) begin
      fails++;
      $display("FAIL areset_now1: got v=%b req=%b pc=%h inst=%h addr=%h, want 0 0 00 0000 00",
               valid1, req1, pc1, inst1, addr1);
    end
    tests++;
    if (valid2 !== 1'b0 || addr2 !== 8'hFE) begin
      fails++; $display("FAIL areset_now2: got v=%b addr=%h, want 0 fe", valid2, addr2);
    end
    next_cycle();
    reset = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (k == 0 && (req1 !== 1'b1 || addr1 !== 8'h00 || addr2 !== 8'hFE || valid1 !== 1'b0)) begin
        fails++;
        $display("FAIL areset_refetch: got req=%b addr1=%h addr2=%h v=%b, want 1 00 fe 0",
                 req1, addr1, addr2, valid1);
      end else if (k == 1 && valid1 !== 1'b0) begin
        fails++; $display("FAIL areset_bubble: got v=%b, want 0", valid1);
      end else if (k >= 2 && (valid1 !== 1'b1 || pc1 !== 8'(k-2))) begin
        fails++; $display("FAIL areset_head c%0d: got v=%b pc=%h, want 1 %h", k, valid1, pc1, 8'(k-2));
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_pc;
    int         gap;
    int         t;
    ready1 = 1'b1;
    do_reset();
    exp_pc = 8'h00;
    gap = 0;
    for (int c = 0; c < 1500; c++) begin
      ready1 = ($urandom_range(0, 3) != 0);
      redir1 = ($urandom_range(0, 7) == 0);
      bpc1   = 8'($urandom);
      boff1  = 8'($urandom);
      @(negedge clk);
      if (redir1) begin
        tests++;
        if (req1 !== 1'b0) begin
          fails++; $display("FAIL rnd_redir_req c%0d: got req=%b, want 0", c, req1);
        end
      end
      if (valid1 === 1'b1 && ready1) begin
        tests++;
        if (pc1 !== exp_pc || inst1 !== rom(exp_pc)) begin
          fails++;
          $display("FAIL rnd_order c%0d: got pc=%h inst=%h, want %h %h", c, pc1, inst1, exp_pc, rom(exp_pc));
        end
        exp_pc = exp_pc + 8'h01;
      end
      gap = (valid1 === 1'b1) ? 0 : gap + 1;
      tests++;
      if (gap > 3) begin
        fails++; $display("FAIL rnd_starve c%0d: got %0d idle cycles, want <= 3", c, gap);
      end
      if (redir1) begin
        t = int'(bpc1) + ((boff1 >= 8'h80) ? int'(boff1) - 256 : int'(boff1));
        exp_pc = t[7:0];
        gap = 0;
      end
      next_cycle();
    end
    redir1 = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0;
    ready1 = 1'b0; redir1 = 1'b0; bpc1 = '0; boff1 = '0;
    ready2 = 1'b0; redir2 = 1'b0; bpc2 = '0; boff2 = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap_and_abs();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
